jtag_master: RTL and testbench

JTAG_MASTER -- requirements
Module: jtag_master

---
 rtl/jtag_master.sv | 183 ++++++++++++++++++
 tb/tb_jtag_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_master.sv
// JTAG TAP master: runs a TLR/idle init sequence after reset, then executes
// IR/DR shift, TAP reset and run-idle commands with a ready/valid response.
module jtag_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        jtag_tck,
    output logic        jtag_tms,
    output logic        jtag_tdi,
    output logic        jtag_trst,
    input  logic        jtag_tdo
);

    typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, RUN, RESP} state_t;

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    state_t      state;
    logic [1:0]  op;
    logic [5:0]  len;
    logic [5:0]  len_c;
    logic [31:0] sh;
    logic [5:0]  cnt;
    logic [7:0]  div;

    function automatic logic [5:0] pre_len(input logic [1:0] o);
        case (o)
            2'b01:   return 6'd4;
            2'b10:   return 6'd3;
            default: return 6'd6;
        endcase
    endfunction

    // Op 00 reuses PRE to walk the six-period test-logic-reset pattern
    function automatic logic pre_tms(input logic [1:0] o, input logic [5:0] i);
        case (o)
            2'b01:   return i < 6'd2;
            2'b10:   return i == 6'd0;
            default: return i < 6'd5;
        endcase
    endfunction

    always_comb begin
        len_c = (cmd_len > 6'd32) ? 6'd32 : cmd_len;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            op        <= '0;
            len       <= '0;
            sh        <= '0;
            cnt       <= '0;
            div       <= '0;
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
            jtag_trst <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (busy) begin
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        op        <= cmd_op;
                        len       <= len_c;
                        sh        <= cmd_data;
                        rsp_data  <= '0;
                        cnt       <= '0;
                        div       <= '0;
                        jtag_tck  <= 1'b0;
                        jtag_tdi  <= 1'b0;
                        if (cmd_op == 2'b11) begin
                            state    <= (len_c == 6'd0) ? RESP : RUN;
                            jtag_tms <= 1'b0;
                        end else if (cmd_op != 2'b00 && len_c == 6'd0) begin
                            state <= RESP;
                        end else begin
                            state    <= PRE;
                            jtag_tms <= 1'b1;
                        end
                    end
                end
                // busy still high on entry marks the cycle that raises rsp_valid
                RESP: begin
                    if (busy) begin
                        busy      <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    if (!busy) begin
                        busy      <= 1'b1;
                        jtag_trst <= 1'b1;
                    end else if (div != DIV_MAX) begin
                        div <= div + 8'd1;
                    end else begin
                        div <= '0;
                        if (!jtag_tck) begin
                            jtag_tck <= 1'b1;
                            if (state == SHIFT) rsp_data[cnt[4:0]] <= jtag_tdo;
                        end else begin
                            jtag_tck <= 1'b0;
                            case (state)
                                INIT: begin
                                    if (cnt == 6'd5) begin
                                        state <= IDLE;
                                    end else begin
                                        cnt      <= cnt + 6'd1;
                                        jtag_tms <= cnt < 6'd4;
                                    end
                                end
                                PRE: begin
                                    if (cnt == pre_len(op) - 6'd1) begin
                                        cnt <= '0;
                                        if (op == 2'b00) begin
                                            state <= RESP;
                                        end else begin
                                            state    <= SHIFT;
                                            jtag_tms <= len == 6'd1;
                                            jtag_tdi <= sh[0];
                                        end
                                    end else begin
                                        cnt      <= cnt + 6'd1;
                                        jtag_tms <= pre_tms(op, cnt + 6'd1);
                                    end
                                end
                                SHIFT: begin
                                    if (cnt == len - 6'd1) begin
                                        state    <= POST;
                                        cnt      <= '0;
                                        jtag_tms <= 1'b1;
                                        jtag_tdi <= 1'b0;
                                    end else begin
                                        cnt      <= cnt + 6'd1;
                                        jtag_tms <= (cnt + 6'd2) == len;
                                        jtag_tdi <= sh[1];
                                        sh       <= sh >> 1;
                                    end
                                end
                                POST: begin
                                    if (cnt == 6'd0) begin
                                        cnt      <= 6'd1;
                                        jtag_tms <= 1'b0;
                                    end else begin
                                        state <= RESP;
                                    end
                                end
                                RUN: begin
                                    if (cnt == len - 6'd1) state <= RESP;
                                    else                   cnt   <= cnt + 6'd1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Randomized bench for jtag_master: a period-level model builds the TMS/TDI
// stream and response per command; a monitor checks TCK timing every cycle.
module tb_jtag_master;

    localparam int unsigned DIV = 4;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [5:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;
    logic        jtag_tck, jtag_tms, jtag_tdi, jtag_trst, jtag_tdo;
    logic [1:0]  tdo_mode = '0;

    jtag_master #(.CLK_DIV(DIV)) dut (
        .clk_in(clk_in), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms),
        .jtag_tdi(jtag_tdi), .jtag_trst(jtag_trst), .jtag_tdo(jtag_tdo)
    );

    always #5 clk_in = ~clk_in;

    // TDO source: 0 loopback, 1 inverted loopback, 2 tied 0, 3 tied 1
    always_comb begin
        case (tdo_mode)
            2'd0:    jtag_tdo = jtag_tdi;
            2'd1:    jtag_tdo = ~jtag_tdi;
            2'd2:    jtag_tdo = 1'b0;
            default: jtag_tdo = 1'b1;
        endcase
    end

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        exp_tms[$];
    logic        exp_tdi[$];
    logic [31:0] exp_rsp;

    function automatic logic tdo_of(input logic b);
        case (tdo_mode)
            2'd0:    return b;
            2'd1:    return ~b;
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic push(input logic t, input logic d);
        exp_tms.push_back(t);
        exp_tdi.push_back(d);
    endtask

    task automatic build_model(input logic [1:0] op, input int unsigned len, input logic [31:0] data);
        int unsigned n;
        n = (len > 32) ? 32 : len;
        exp_tms.delete();
        exp_tdi.delete();
        exp_rsp = '0;
        if (op == 2'b00) begin
            for (int i = 0; i < 6; i++) push(i < 5, 1'b0);
        end else if (op == 2'b11) begin
            for (int unsigned i = 0; i < n; i++) push(1'b0, 1'b0);
        end else if (n > 0) begin
            if (op == 2'b01) push(1'b1, 1'b0);
            push(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
            for (int unsigned i = 0; i < n; i++) begin
                push(i == n - 1, data[i]);
                exp_rsp[i] = tdo_of(data[i]);
            end
            push(1'b1, 1'b0); push(1'b0, 1'b0);
        end
    endtask

    // ---------------- cycle monitor ----------------
    logic        mon_tms[$];
    logic        mon_tdi[$];
    logic        p_tck, p_tms, p_tdi, p_busy, p_rsp;
    int unsigned lowc, highc, since_fall, rsp_rises = 0;

    always @(negedge clk_in) begin
        if (!reset) begin
            mon_tms.delete();
            mon_tdi.delete();
            lowc = 0; highc = 0; since_fall = 0;
        end else begin
            since_fall++;
            if (!busy) begin
                chk("tck_idle", jtag_tck, 1'b0);
                lowc = 0;
            end
            if (jtag_tck && !p_tck) begin
                chk("tck_low_len", lowc, DIV);
                lowc = 0; highc = 0;
                mon_tms.push_back(jtag_tms);
                mon_tdi.push_back(jtag_tdi);
            end else if (!jtag_tck && p_tck) begin
                chk("tck_high_len", highc, DIV);
                since_fall = 0; lowc = 0;
            end
            if (busy && !jtag_tck) lowc++;
            if (jtag_tck) highc++;
            if (jtag_tms != p_tms || jtag_tdi != p_tdi)
                chk("tms_tdi_at_fall", (!jtag_tck && p_tck) || (busy && !p_busy), 1'b1);
            if (rsp_valid && !p_rsp) begin
                rsp_rises++;
                chk("busy_low_at_rsp", busy, 1'b0);
                if (mon_tms.size() > 0) chk("rsp_latency", since_fall, 1);
            end
        end
        p_tck = jtag_tck; p_tms = jtag_tms; p_tdi = jtag_tdi;
        p_busy = busy; p_rsp = rsp_valid;
    end

    // ---------------- driver tasks ----------------
    logic [63:0] last_tms_vec;
    logic [31:0] last_rsp;
    int unsigned last_periods;

    function automatic logic [63:0] pack(input logic q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v = {v[62:0], q[i]};
        return v;
    endfunction

    task automatic wait_ready();
        int unsigned w = 0;
        @(negedge clk_in);
        while (!cmd_ready && w < 1000) begin
            @(negedge clk_in);
            w++;
        end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
    endtask

    task automatic send_cmd(input logic [1:0] op, input int unsigned len, input logic [31:0] data);
        wait_ready();
        build_model(op, len, data);
        mon_tms.delete();
        mon_tdi.delete();
        cmd_valid = 1'b1; cmd_op = op; cmd_len = 6'(len); cmd_data = data;
        @(posedge clk_in);
        #1 cmd_valid = 1'b0;
        @(negedge clk_in);
        chk("busy_after_accept", busy, 1'b1);
    endtask

    task automatic finish_cmd(input int unsigned hold);
        int unsigned w = 0;
        logic [31:0] held;
        while (!rsp_valid && w < 2000) begin
            @(negedge clk_in);
            w++;
        end
        chk("rsp_valid_wait", rsp_valid, 1'b1);
        held = rsp_data;
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk_in);
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_data", rsp_data, held);
            chk("hold_no_ready", cmd_ready, 1'b0);
            chk("hold_no_tck", jtag_tck, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk_in);
        rsp_ready = 1'b0;
        chk("cmd_ready_after_rsp", cmd_ready, 1'b1);
        chk("rsp_valid_cleared", rsp_valid, 1'b0);
        chk("rsp_data", held, exp_rsp);
        chk("period_count", mon_tms.size(), exp_tms.size());
        chk("tms_stream", pack(mon_tms), pack(exp_tms));
        chk("tdi_stream", pack(mon_tdi), pack(exp_tdi));
        last_tms_vec = pack(mon_tms);
        last_rsp = held;
        last_periods = mon_tms.size();
    endtask

    task automatic chk_reset_vals();
        chk("rst_tck", jtag_tck, 1'b0);
        chk("rst_tms", jtag_tms, 1'b1);
        chk("rst_tdi", jtag_tdi, 1'b0);
        chk("rst_trst", jtag_trst, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
    endtask

    task automatic check_init();
        @(posedge clk_in);
        #1 chk("busy_first_edge", busy, 1'b1);
        wait_ready();
        chk("init_periods", mon_tms.size(), 6);
        chk("init_tms", pack(mon_tms), 64'b111110);
        chk("init_tdi", pack(mon_tdi), 64'b0);
        chk("init_trst", jtag_trst, 1'b1);
        chk("init_busy", busy, 1'b0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned w;
        int unsigned rises_before;
        repeat (3) @(negedge clk_in);
        chk_reset_vals();
        #2 reset = 1'b1;
        check_init();

        tdo_mode = 2'd0;
        send_cmd(2'b10, 8, 32'hA5);
        finish_cmd(0);
        chk("dr8_periods", last_periods, 13);
        chk("dr8_tms", last_tms_vec, 64'b1000000000110);
        chk("dr8_rsp", last_rsp, 32'h000000A5);

        tdo_mode = 2'd3;
        send_cmd(2'b01, 5, 32'h0);
        finish_cmd(0);
        chk("ir5_periods", last_periods, 11);
        chk("ir5_tms", last_tms_vec, 64'b11000000110);
        chk("ir5_rsp", last_rsp, 32'h0000001F);

        tdo_mode = 2'd2;
        send_cmd(2'b10, 16, 32'h1234_ABCD);
        finish_cmd(20);

        send_cmd(2'b00, 3, 32'hFFFF_FFFF);
        finish_cmd(1);
        chk("tlr_periods", last_periods, 6);
        chk("tlr_rsp", last_rsp, 32'h0);

        send_cmd(2'b11, 10, 32'h0);
        finish_cmd(0);
        chk("run10_periods", last_periods, 10);
        send_cmd(2'b11, 0, 32'h0);
        finish_cmd(0);
        chk("run0_periods", last_periods, 0);

        tdo_mode = 2'd0;
        send_cmd(2'b10, 0, 32'hFFFF_FFFF);
        finish_cmd(0);
        chk("len0_periods", last_periods, 0);
        chk("len0_rsp", last_rsp, 32'h0);
        send_cmd(2'b10, 40, 32'hFFFF_FFFF);
        finish_cmd(0);
        chk("len40_periods", last_periods, 37);
        chk("len40_rsp", last_rsp, 32'hFFFF_FFFF);

        for (int i = 0; i < 30; i++) begin
            tdo_mode = 2'($urandom_range(0, 3));
            send_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 40), $urandom);
            finish_cmd($urandom_range(0, 3));
        end

        // Reset while shifting bit 3 of an 8-bit DR scan
        tdo_mode = 2'd0;
        send_cmd(2'b10, 8, 32'h5A);
        w = 0;
        while (mon_tms.size() < 7 && w < 500) begin
            @(negedge clk_in);
            #1 w++;
        end
        chk("reach_shift_bit3", mon_tms.size(), 7);
        #2 reset = 1'b0;
        #1 chk_reset_vals();
        rises_before = rsp_rises;
        repeat (3) @(negedge clk_in);
        #2 reset = 1'b1;
        check_init();
        repeat (5) @(negedge clk_in);
        chk("no_stale_rsp", rsp_rises, rises_before);
        chk("no_stale_valid", rsp_valid, 1'b0);

        tdo_mode = 2'd1;
        send_cmd(2'b10, 12, 32'h0000_0F3C);
        finish_cmd(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
